// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline memory stage and its MW register.
package pipeline_pkg;

    // Width of a register-file address (16 architectural registers).
    localparam int REG_ADDR_W = 4;

    // Memory-access FSM: IDLE accepts a new access, WAIT holds it until ack or timeout.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Control bits carried by the MW pipeline register into writeback.
    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
    } mw_ctrl_t;

endpackage

// File: rtl/mem_stage_regmw.sv
// MW pipeline register: captures M-stage results for writeback, with a bubble input
// that zeroes the control bits while leaving the data fields untouched.
module RegMW
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_bubble,
    input  logic                  i_load_rdata,
    input  mw_ctrl_t              i_ctrl,
    input  logic [WIDTH-1:0]      i_alu,
    input  logic [WIDTH-1:0]      i_rdata,
    input  logic [REG_ADDR_W-1:0] i_wa3,
    output mw_ctrl_t              o_ctrl,
    output logic [WIDTH-1:0]      o_alu,
    output logic [WIDTH-1:0]      o_rdata,
    output logic [REG_ADDR_W-1:0] o_wa3
);

    mw_ctrl_t              r_ctrl;
    logic [WIDTH-1:0]      r_alu;
    logic [WIDTH-1:0]      r_rdata;
    logic [REG_ADDR_W-1:0] r_wa3;

    // Register update: clear on reset, bubble kills controls only, otherwise load M values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ctrl  <= '0;
            r_alu   <= '0;
            r_rdata <= '0;
            r_wa3   <= '0;
        end else if (i_bubble) begin
            r_ctrl  <= '0;
        end else begin
            r_ctrl  <= i_ctrl;
            r_alu   <= i_alu;
            r_wa3   <= i_wa3;
            if (i_load_rdata) begin
                r_rdata <= i_rdata;
            end
        end
    end

    assign o_ctrl  = r_ctrl;
    assign o_alu   = r_alu;
    assign o_rdata = r_rdata;
    assign o_wa3   = r_wa3;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores on a req/ack bus, stalls upstream while an access
// is outstanding, aborts after TIMEOUT wait cycles, and feeds the MW register.
//
// Bus handshake: mem_req is held high with stable mem_addr/mem_we/mem_wdata until the
// cycle in which mem_ack=1 (completion) or the timeout abort cycle; mem_ack is only
// meaningful while mem_req=1 and is ignored otherwise (including during reset).
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PCSrcM,
    input  logic                  RegWriteM,
    input  logic                  MemWriteM,
    input  logic                  MemtoRegM,
    input  logic [WIDTH-1:0]      ALUResultM,
    input  logic [WIDTH-1:0]      WriteDataM,
    input  logic [REG_ADDR_W-1:0] WA3M,
    input  logic                  mem_ack,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [WIDTH-1:0]      mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  StallM,
    output logic                  MemErrM,
    output logic [WIDTH-1:0]      ALUResultMFB,
    output logic                  PCSrcW,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic [WIDTH-1:0]      ReadDataW,
    output logic [WIDTH-1:0]      ALUOutW,
    output logic [REG_ADDR_W-1:0] WA3W,
    output mem_state_t            o_dbg_state
);

    // Counter holds up to 255 wait cycles; the abort fires on its last value.
    localparam int          CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       r_state;
    mem_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic             w_store;
    logic             w_load;
    logic             w_access;
    logic             w_req;
    logic             w_abort;
    logic             w_complete;
    logic             w_stall;
    logic             w_bubble;
    mw_ctrl_t         w_ctrl_m;
    mw_ctrl_t         w_ctrl_w;

    // A store takes priority when both MemWrite and MemtoReg are set.
    assign w_store  = MemWriteM;
    assign w_load   = MemtoRegM & ~MemWriteM;
    assign w_access = w_store | w_load;

    // State register; reset forces IDLE even mid-access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, request and abort decode; reset suppresses the request and any abort.
    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                w_req = w_access;
                if (w_access && !mem_ack) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                w_req = 1'b1;
                if (mem_ack) begin
                    w_next_state = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (!reset) begin
            w_req   = 1'b0;
            w_abort = 1'b0;
        end
    end

    // Wait counter: zero whenever IDLE so each WAIT period starts counting from 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Error flag: one-cycle pulse in the cycle after an abort.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
        end
    end

    // An ack beats a simultaneous timeout because abort is only decoded without ack.
    assign w_complete = w_req & mem_ack;
    assign w_stall    = w_req & ~mem_ack & ~w_abort;
    assign w_bubble   = w_stall | w_abort;

    assign w_ctrl_m.pcsrc    = PCSrcM;
    assign w_ctrl_m.regwrite = RegWriteM;
    assign w_ctrl_m.memtoreg = MemtoRegM;

    RegMW #(
        .WIDTH(WIDTH)
    ) u_regmw (
        .clk          (clk),
        .reset        (reset),
        .i_bubble     (w_bubble),
        .i_load_rdata (w_load & w_complete),
        .i_ctrl       (w_ctrl_m),
        .i_alu        (ALUResultM),
        .i_rdata      (mem_rdata),
        .i_wa3        (WA3M),
        .o_ctrl       (w_ctrl_w),
        .o_alu        (ALUOutW),
        .o_rdata      (ReadDataW),
        .o_wa3        (WA3W)
    );

    assign mem_req      = w_req;
    assign mem_we       = w_store;
    assign mem_addr     = {ALUResultM[WIDTH-1:2], 2'b00};
    assign mem_wdata    = WriteDataM;
    assign StallM       = w_stall;
    assign MemErrM      = r_err;
    assign ALUResultMFB = ALUResultM;
    assign PCSrcW       = w_ctrl_w.pcsrc;
    assign RegWriteW    = w_ctrl_w.regwrite;
    assign MemtoRegW    = w_ctrl_w.memtoreg;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a cycle-level reference model
// that tracks how many stall cycles the current access has already spent.
module tb_mem_stage;
  import pipeline_pkg::*;

  localparam int W  = 32;
  localparam int TO = 4;
  localparam int EB = 1 + 1 + 3 + 4 + W + W;  // state, err, ctrl, wa3, alu, rdata

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          PCSrcM = 1'b0, RegWriteM = 1'b0, MemWriteM = 1'b0, MemtoRegM = 1'b0;
  logic [W-1:0]  ALUResultM = '0, WriteDataM = '0, mem_rdata = '0;
  logic [3:0]    WA3M = '0;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_we, StallM, MemErrM, PCSrcW, RegWriteW, MemtoRegW;
  logic [W-1:0]  mem_addr, mem_wdata, ALUResultMFB, ReadDataW, ALUOutW;
  logic [3:0]    WA3W;
  mem_state_t    dbg_state;

  mem_stage #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .StallM(StallM), .MemErrM(MemErrM), .ALUResultMFB(ALUResultMFB),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EB-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_n = 0;        // stall cycles already spent by the current access
  logic         m_stalled = 1'b0;
  logic         e_err = 1'b0, e_pc = 1'b0, e_rw = 1'b0, e_m2r = 1'b0;
  logic [3:0]   e_wa3 = '0;
  logic [W-1:0] e_alu = '0, e_rd = '0;
  int           obs_stall = 0;

  // One clock: check combinational outputs mid-cycle, advance the model, check registers.
  task automatic step();
    logic acc, ld, req, abrt, stl;
    logic [EB-1:0] x;
    @(negedge clk);
    acc  = MemWriteM | MemtoRegM;
    ld   = MemtoRegM & ~MemWriteM;
    req  = reset && (acc || m_n > 0);
    abrt = req && !mem_ack && (m_n == TO);
    stl  = req && !mem_ack && !abrt;
    check("mem_req", W'(mem_req), W'(req));
    check("StallM", W'(StallM), W'(stl));
    check("mem_addr", mem_addr, ALUResultM & ~32'h3);
    check("mem_we", W'(mem_we), W'(MemWriteM));
    check("mem_wdata", mem_wdata, WriteDataM);
    check("fwd", ALUResultMFB, ALUResultM);
    if (StallM === 1'b1) obs_stall++;
    if (!reset) begin
      m_n = 0; e_err = 0; e_pc = 0; e_rw = 0; e_m2r = 0; e_wa3 = '0; e_alu = '0; e_rd = '0;
    end else begin
      e_err = abrt;
      if (stl || abrt) begin
        m_n = stl ? m_n + 1 : 0;
        e_pc = 0; e_rw = 0; e_m2r = 0;
      end else begin
        m_n = 0;
        e_pc = PCSrcM; e_rw = RegWriteM; e_m2r = MemtoRegM;
        e_wa3 = WA3M; e_alu = ALUResultM;
        if (ld && req) e_rd = mem_rdata;
      end
    end
    m_stalled = stl;
    exp_q.push_back({(m_n > 0), e_err, e_pc, e_rw, e_m2r, e_wa3, e_alu, e_rd});
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check("dbg_wait", W'(dbg_state == WAIT), W'(x[EB-1]));
    check("MemErrM", W'(MemErrM), W'(x[EB-2]));
    check("PCSrcW", W'(PCSrcW), W'(x[EB-3]));
    check("RegWriteW", W'(RegWriteW), W'(x[EB-4]));
    check("MemtoRegW", W'(MemtoRegW), W'(x[EB-5]));
    check("WA3W", W'(WA3W), W'(x[2*W+3:2*W]));
    check("ALUOutW", ALUOutW, x[2*W-1:W]);
    check("ReadDataW", ReadDataW, x[W-1:0]);
  endtask

  // ---------------- driver ----------------
  // Presents one M-stage op and holds it until the model says it left M.
  // waits: cycle index of the ack (-1 = never); rst_at: cycle index to pulse reset (-1 = none).
  task automatic run_op(input logic pc, input logic rw, input logic mw, input logic m2r,
                        input logic [W-1:0] alu, input logic [W-1:0] wd, input logic [3:0] wa3,
                        input int waits, input logic [W-1:0] rd, input int rst_at);
    PCSrcM = pc; RegWriteM = rw; MemWriteM = mw; MemtoRegM = m2r;
    ALUResultM = alu; WriteDataM = wd; WA3M = wa3;
    obs_stall = 0;
    for (int c = 0; c < TO + 3; c++) begin
      reset     = (c == rst_at) ? 1'b0 : 1'b1;
      mem_ack   = (c == waits);
      mem_rdata = (c == waits) ? rd : W'($urandom);
      step();
      if (!m_stalled) break;
    end
    reset = 1'b1;
    mem_ack = 1'b0;
    PCSrcM = 0; RegWriteM = 0; MemWriteM = 0; MemtoRegM = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset with a stray ack that must be ignored
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    reset = 1'b1;
    check("rst_RegWriteW", W'(RegWriteW), 0);
    check("rst_ReadDataW", ReadDataW, 0);
    check("rst_MemErrM", W'(MemErrM), 0);

    // non-memory op
    run_op(0, 1, 0, 0, 32'h0000_0042, 32'h0, 4'd3, -1, 32'h0, -1);
    check("nm_RegWriteW", W'(RegWriteW), 1);
    check("nm_ALUOutW", ALUOutW, 32'h42);
    check("nm_WA3W", W'(WA3W), 3);

    // zero-wait load
    run_op(0, 1, 0, 1, 32'h104, 32'h0, 4'd5, 0, 32'hDEAD_BEEF, -1);
    check("zl_ReadDataW", ReadDataW, 32'hDEAD_BEEF);
    check("zl_MemtoRegW", W'(MemtoRegW), 1);
    check("zl_stalls", obs_stall, 0);

    // 3-wait store
    run_op(0, 0, 1, 0, 32'h203, 32'h55, 4'd0, 3, 32'h0, -1);
    check("st3_stalls", obs_stall, 3);
    check("st3_idle", W'(dbg_state == IDLE), 1);

    // timeout on a load: TO stall cycles, then one error pulse
    run_op(0, 1, 0, 1, 32'h300, 32'h0, 4'd7, -1, 32'h0, -1);
    check("to_stalls", obs_stall, TO);
    check("to_err", W'(MemErrM), 1);
    check("to_RegWriteW", W'(RegWriteW), 0);
    step();
    check("to_err_clear", W'(MemErrM), 0);

    // reset on the second wait cycle, then a normal load
    run_op(0, 1, 0, 1, 32'h400, 32'h0, 4'd9, -1, 32'h0, 2);
    check("rmw_ALUOutW", ALUOutW, 0);
    check("rmw_WA3W", W'(WA3W), 0);
    run_op(0, 1, 0, 1, 32'h408, 32'h0, 4'd9, 1, 32'h1234_5678, -1);
    check("rmw_ReadDataW", ReadDataW, 32'h1234_5678);

    // ack coinciding with the last wait cycle: completion wins
    run_op(0, 1, 0, 1, 32'h500, 32'h0, 4'd2, TO, 32'hCAFE_F00D, -1);
    check("co_err", W'(MemErrM), 0);
    check("co_ReadDataW", ReadDataW, 32'hCAFE_F00D);

    // randomized ops: kind, wait count (beyond TO means timeout), occasional reset
    for (int i = 0; i < 300; i++) begin
      int kind;
      int waits;
      int rst_at;
      kind   = $urandom_range(0, 3);
      waits  = $urandom_range(0, TO + 2);
      rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, TO) : -1;
      run_op(1'($urandom), 1'($urandom), (kind >= 2), (kind == 1) || (kind == 3 && 1'($urandom)),
             W'($urandom), W'($urandom), 4'($urandom), waits, W'($urandom), rst_at);
      if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'($urandom);
        step();
        mem_ack = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
